// File: rtl/sw_event_gen.sv
// sw_event_gen -- push-button front-end for the digital clock controller.
//
// Synchronises raw active-low switches, debounces them on a slow sample tick
// and emits clean levels plus single-clk press/release pulses.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_sw[N_SW]     raw switches, 0 = pressed, asynchronous to clk
//   o_sw_level     debounced level, 1 = pressed
//   o_sw_press     1-clk pulse per accepted press (and per auto-repeat)
//   o_sw_release   1-clk pulse per accepted release
//   o_tick         1-clk pulse per debounce sample tick
//
// Optional feature macro: SW_AUTO_REPEAT_EN
//   When defined, a held switch produces extra press pulses: one RPT_DELAY
//   ticks after the press pulse, then one every RPT_PERIOD ticks.
//
// o_tick, the level and the event pulses are all registered on the edge that
// closes the tick cycle, so an event pulse is always coincident with o_tick.

// Per-channel debounce + event FSM.
module sw_event_chan #(
    parameter int DB_TICKS   = 3,
    parameter int RPT_DELAY  = 50,
    parameter int RPT_PERIOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,     // debounce update enable (tick cycle)
    input  logic sample_i,   // synchronised sample, 1 = pressed
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    if (DB_TICKS < 1 || DB_TICKS > 15 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
        $error("sw_event_chan: parameter out of range");
    end

    localparam logic [3:0] DB_M1 = 4'(DB_TICKS - 1);

`ifdef SW_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_REPEAT   = 2'd2
    } state_e;

    localparam logic [7:0] RPT_DLY_M1 = 8'(RPT_DELAY - 1);
    localparam logic [7:0] RPT_PER_M1 = 8'(RPT_PERIOD - 1);

    logic [7:0] rpt_q, rpt_d;
`else
    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_e;
`endif

    state_e     state_q, state_d;
    logic [3:0] stab_q, stab_d;
    logic       press_q, press_d;
    logic       rel_q, rel_d;

    assign level_o   = (state_q != ST_RELEASED);
    assign press_o   = press_q;
    assign release_o = rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASED;
            stab_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef SW_AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef SW_AUTO_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
`ifdef SW_AUTO_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (tick_i) begin
            if (sample_i != level_o && stab_q >= DB_M1) begin
                // DB_TICKS-th consecutive differing sample: accept the change.
                stab_d = '0;
                if (level_o) begin
                    state_d = ST_RELEASED;
                    rel_d   = 1'b1;
                end else begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
`ifdef SW_AUTO_REPEAT_EN
                rpt_d = '0;
`endif
            end else begin
                // Any agreeing sample throws away partial progress.
                stab_d = (sample_i == level_o) ? 4'd0 : stab_q + 4'd1;
`ifdef SW_AUTO_REPEAT_EN
                // Repeat counter counts ticks since the last press pulse.
                if (state_q == ST_PRESSED) begin
                    if (rpt_q == RPT_DLY_M1) begin
                        state_d = ST_REPEAT;
                        press_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + 8'd1;
                    end
                end else if (state_q == ST_REPEAT) begin
                    if (rpt_q == RPT_PER_M1) begin
                        press_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + 8'd1;
                    end
                end
`endif
            end
        end
    end

endmodule

module sw_event_gen #(
    parameter int N_SW       = 3,
    parameter int TICK_DIV   = 500000,
    parameter int DB_TICKS   = 3,
    parameter int RPT_DELAY  = 50,
    parameter int RPT_PERIOD = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] i_sw,
    output logic [N_SW-1:0] o_sw_level,
    output logic [N_SW-1:0] o_sw_press,
    output logic [N_SW-1:0] o_sw_release,
    output logic            o_tick
);

    localparam logic [31:0] TD_M1 = 32'(TICK_DIV - 1);

    logic [N_SW-1:0] sync1_q, sync2_q;
    logic [31:0]     tcnt_q, tcnt_d;
    logic            tick_en;
    logic            tick_q;

    // Synchronisers reset to 1 so reset exit looks like "all released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= i_sw;
            sync2_q <= sync1_q;
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_en;
        end
    end

    assign tick_en = (tcnt_q == TD_M1);
    assign tcnt_d  = tick_en ? 32'd0 : tcnt_q + 32'd1;
    assign o_tick  = tick_q;

    for (genvar g = 0; g < N_SW; g++) begin : g_chan
        sw_event_chan #(
            .DB_TICKS  (DB_TICKS),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick_en),
            .sample_i (~sync2_q[g]),
            .level_o  (o_sw_level[g]),
            .press_o  (o_sw_press[g]),
            .release_o(o_sw_release[g])
        );
    end

endmodule

// File: tb/tb_sw_event_gen.sv
// Randomised + directed bench for sw_event_gen. A reference model turns the
// applied switch history into expected per-cycle status and event records;
// a monitor pops and compares them against the DUT outputs.
module tb_sw_event_gen;

    localparam int N_SW = 3;
    localparam int TD   = 10;
    localparam int DB   = 3;
    localparam int RD   = 5;
    localparam int RP   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_SW-1:0] i_sw = '1;
    logic [N_SW-1:0] o_sw_level, o_sw_press, o_sw_release;
    logic            o_tick;

    always #5 clk = ~clk;

    sw_event_gen #(
        .N_SW(N_SW), .TICK_DIV(TD), .DB_TICKS(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
        .o_sw_level(o_sw_level), .o_sw_press(o_sw_press),
        .o_sw_release(o_sw_release), .o_tick(o_tick)
    );

    typedef struct { int cyc; logic [N_SW-1:0] press; logic [N_SW-1:0] rel; } ev_t;
    typedef struct { logic tick; logic [N_SW-1:0] level; } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycle index n = number of clk edges since reset release. The input seen
    // at negedge n is what the DUT captures on edge n+1; a debounce tick is
    // applied on every edge E with E % TD == 0 using the input from edge E-2.
    logic [N_SW-1:0] hist[$];
    bit              smp[N_SW][$];   // tick samples since the last level change
    int              held[N_SW];     // ticks the level has been 1 since press
    logic [N_SW-1:0] m_lvl, m_s, m_pr, m_rl;
    int              mn, m_e;
    bit              m_tk, m_agree;

    always @(negedge clk) begin
        if (!rst_n) begin
            mn = -1;
            hist.delete();
            ev_q.delete();
            st_q.delete();
            m_lvl = '0;
            for (int i = 0; i < N_SW; i++) begin
                smp[i].delete();
                held[i] = 0;
            end
            st_q.push_back('{tick: 1'b0, level: '0});
        end else begin
            mn++;
            hist.push_back(i_sw);
            m_e  = mn + 1;
            m_tk = (m_e % TD == 0);
            m_pr = '0;
            m_rl = '0;
            if (m_tk) begin
                m_s = (mn >= 2) ? ~hist[mn-2] : '0;
                for (int i = 0; i < N_SW; i++) begin
                    smp[i].push_back(m_s[i]);
                    if (smp[i].size() > DB) void'(smp[i].pop_front());
                    m_agree = 1'b0;
                    foreach (smp[i][k]) if (smp[i][k] == m_lvl[i]) m_agree = 1'b1;
                    if (smp[i].size() == DB && !m_agree) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) m_pr[i] = 1'b1; else m_rl[i] = 1'b1;
                        smp[i].delete();
                        held[i] = 0;
                    end
`ifdef SW_AUTO_REPEAT_EN
                    else if (m_lvl[i]) begin
                        held[i]++;
                        if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0))
                            m_pr[i] = 1'b1;
                    end
`endif
                end
            end
            st_q.push_back('{tick: m_tk, level: m_lvl});
            if ((m_pr | m_rl) != '0) ev_q.push_back('{cyc: m_e, press: m_pr, rel: m_rl});
        end
    end

    // ---------------- monitor ----------------
    int  mc;
    st_t st;
    ev_t ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            mc = -1;
            chk("reset_outputs", {o_tick, o_sw_level, o_sw_press, o_sw_release}, 32'd0);
        end else begin
            mc++;
            if (st_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL status_queue: empty at cycle %0d", mc);
            end else begin
                st = st_q.pop_front();
                chk("tick", {31'd0, o_tick}, {31'd0, st.tick});
                chk("level", 32'(o_sw_level), 32'(st.level));
            end
            chk("press_release_excl", 32'(o_sw_press & o_sw_release), 32'd0);
            while (ev_q.size() > 0 && ev_q[0].cyc < mc) begin
                ev = ev_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_event: cycle %0d press=%b release=%b never seen",
                         ev.cyc, ev.press, ev.rel);
            end
            if ((o_sw_press | o_sw_release) != '0) begin
                if (ev_q.size() == 0 || ev_q[0].cyc != mc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_event: cycle %0d got press=%b release=%b, expected none",
                             mc, o_sw_press, o_sw_release);
                end else begin
                    ev = ev_q.pop_front();
                    chk("press", 32'(o_sw_press), 32'(ev.press));
                    chk("release", 32'(o_sw_release), 32'(ev.rel));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    int lat, cnt, lo, hi;
    bit seen;

    initial begin
        // Reset with toggling switches; outputs must stay 0.
        for (int k = 0; k < 6; k++) begin
            i_sw = N_SW'($urandom);
            step(1);
        end
        i_sw  = '1;
        rst_n = 1'b1;
        step(1000);

        // Clean press on ch0 with explicit latency bound.
        i_sw[0] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (o_sw_press[0]) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        n_cmp++;
        if (!seen || lat < 2 + (DB - 1) * TD + 1 || lat > 2 + (DB + 1) * TD) begin
            n_bad++;
            $display("FAIL press_latency: seen=%0d latency=%0d, required %0d..%0d",
                     seen, lat, 2 + (DB - 1) * TD + 1, 2 + (DB + 1) * TD);
        end
        step(60);
        i_sw[0] = 1'b1;
        step(100);

        // Glitch and bounce on ch1.
        i_sw[1] = 1'b0;
        step(25);
        i_sw[1] = 1'b1;
        step(80);
        for (int k = 0; k < 200 / 7; k++) begin
            i_sw[1] = ~i_sw[1];
            step(7);
        end
        i_sw[1] = 1'b1;
        step(80);

        // Simultaneous press on ch0 and ch2.
        i_sw = 3'b010;
        step(100);
        i_sw = 3'b111;
        step(100);

        // Reset while ch1 is held, still held on exit.
        i_sw[1] = 1'b0;
        step(60);
        do_reset(5);
        step(80);
        i_sw[1] = 1'b1;
        step(80);

        // Long hold on ch2: count press pulses.
        cnt = 0;
        i_sw[2] = 1'b0;
        for (int k = 0; k < 260; k++) begin
            @(posedge clk);
            #1;
            if (k == 200) i_sw[2] = 1'b1;
            @(negedge clk);
            if (o_sw_press[2]) cnt++;
        end
`ifdef SW_AUTO_REPEAT_EN
        lo = 8; hi = 9;
`else
        lo = 1; hi = 1;
`endif
        n_cmp++;
        if (cnt < lo || cnt > hi) begin
            n_bad++;
            $display("FAIL hold_press_count: got %0d, required %0d..%0d", cnt, lo, hi);
        end
        step(40);

        // Random switch patterns with occasional resets.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 4));
            i_sw = N_SW'($urandom);
            step($urandom_range(5, 90));
        end

        // Drain and verify nothing is left outstanding.
        i_sw = '1;
        step(150);
        n_cmp++;
        if (ev_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events: %0d pending, expected 0", ev_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
